// File: rtl/counter_pres_gen.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pres_gen
//  Brief    : W-bit LED/sequencer counter stepping once every 2^N clocks,
//             with up-wrap, down-wrap, ping-pong and up-saturate modes,
//             synchronous load, enable, step strobe and terminal-count pulse.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module counter_pres_gen #(
    parameter int W = 8,
    parameter int N = 25
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         en_i,
    input  logic [1:0]   mode_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] data_o,
    output logic         dir_o,
    output logic         tick_o,
    output logic         tc_o
);

    localparam logic [W-1:0] MAX_VAL    = {W{1'b1}};
    localparam logic [W-1:0] ZERO_VAL   = {W{1'b0}};
    localparam logic [W-1:0] ONE_VAL    = W'(1);
    localparam logic [W-1:0] MAX_M1_VAL = MAX_VAL - ONE_VAL;
    localparam logic [N-1:0] PRESC_TOP  = {N{1'b1}};
    localparam logic [N-1:0] PRESC_ONE  = N'(1);

    localparam logic [1:0] MODE_UP_WRAP = 2'b00;
    localparam logic [1:0] MODE_DN_WRAP = 2'b01;
    localparam logic [1:0] MODE_PING    = 2'b10;
    localparam logic [1:0] MODE_UP_SAT  = 2'b11;

    logic [N-1:0] presc_q, presc_d;
    logic [W-1:0] data_q,  data_d;
    logic         dir_q,   dir_d;
    logic         tick_q,  tick_d;
    logic         tc_q,    tc_d;
    logic         step_w;

    // Prescaler roll-over marks the cycle on which the counter advances.
    assign step_w = en_i & ~load_i & (presc_q == PRESC_TOP);

    // Next-state: load beats counting; tick/tc are cleared on every non-step cycle.
    always_comb begin
        presc_d = presc_q;
        data_d  = data_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (load_i) begin
            data_d  = load_val_i;
            presc_d = '0;
            if (load_val_i == ZERO_VAL) begin
                dir_d = 1'b1;
            end else if (load_val_i == MAX_VAL) begin
                dir_d = 1'b0;
            end
        end else if (en_i) begin
            presc_d = presc_q + PRESC_ONE;
            if (step_w) begin
                tick_d = 1'b1;
                case (mode_i)
                    MODE_UP_WRAP: begin
                        dir_d  = 1'b1;
                        data_d = data_q + ONE_VAL;
                        tc_d   = (data_q == MAX_VAL);
                    end
                    MODE_DN_WRAP: begin
                        dir_d  = 1'b0;
                        data_d = data_q - ONE_VAL;
                        tc_d   = (data_q == ZERO_VAL);
                    end
                    MODE_PING: begin
                        // Bounce at either end so each endpoint is shown once per sweep.
                        if (dir_q) begin
                            if (data_q == MAX_VAL) begin
                                data_d = MAX_M1_VAL;
                                dir_d  = 1'b0;
                                tc_d   = 1'b1;
                            end else begin
                                data_d = data_q + ONE_VAL;
                            end
                        end else begin
                            if (data_q == ZERO_VAL) begin
                                data_d = ONE_VAL;
                                dir_d  = 1'b1;
                                tc_d   = 1'b1;
                            end else begin
                                data_d = data_q - ONE_VAL;
                            end
                        end
                    end
                    MODE_UP_SAT: begin
                        dir_d = 1'b1;
                        if (data_q == MAX_VAL) begin
                            tc_d = 1'b1;
                        end else begin
                            data_d = data_q + ONE_VAL;
                        end
                    end
                    default: begin
                        data_d = data_q;
                    end
                endcase
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            presc_q <= '0;
            data_q  <= '0;
            dir_q   <= 1'b1;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign data_o = data_q;
    assign dir_o  = dir_q;
    assign tick_o = tick_q;
    assign tc_o   = tc_q;

endmodule
`default_nettype wire

// File: doc/counter_pres_gen.md
Name: counter_pres_gen

Overview:
- Parametrised successor to the fixed 8-bit prescaled LED up-counter.
- Holds a W-bit counter that steps once every 2^N system clocks. The step strobe comes from an internal prescaler that runs on clk, with no derived clock.
- Adds run-time mode selection: up-wrap, down-wrap, ping-pong and up-saturate. Also adds synchronous load, count enable, step strobe and terminal-count outputs.
- Drives LED banks or feeds sequencers in the same design.

Parameters:
W, 8, counter width in bits; legal range W >= 2; MAX = 2^W-1.
N, 25, prescaler width; one step every 2^N clk cycles; legal range N >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rstn  input  1  synchronous reset, active low.
en  input  1  count enable; 0 freezes prescaler and counter.
mode  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 up-saturate.
load  input  1  synchronous load strobe.
load_val  input  W  value loaded when load=1.
data  output  W  counter value (registered).
dir  output  1  current direction; 1 = up, 0 = down (registered).
tick  output  1  one-cycle pulse; high in the cycle where data shows a newly stepped value.
tc  output  1  one-cycle terminal-count pulse; high together with the post-boundary data value.

Behaviour:
- Reset (rstn=0 at posedge) has the highest priority. It sets data=0, presc=0, dir=1, tick=0, tc=0. Reset mid-count discards all progress.
- Priority order: rstn, then load, then en/step.
- Load (load=1):
  - data<=load_val, presc<=0, tick<=0, tc<=0.
  - Acts regardless of en.
  - If load_val==0, dir<=1. If load_val==MAX, dir<=0. Otherwise dir is unchanged.
- Prescaler: N-bit presc increments each clk while en=1 and load=0. It wraps from 2^N-1 to 0.
- step = en & ~load & (presc == 2^N-1). After reset or load, the first step occurs on the 2^N-th enabled clock edge.
- On a step, tick<=1. On any non-step cycle, tick<=0 and tc<=0.
- Counter action on a step, by mode:
  - 00 up-wrap: data<=data+1. At MAX, data<=0 and tc<=1. dir<=1.
  - 01 down-wrap: data<=data-1. At 0, data<=MAX and tc<=1. dir<=0.
  - 10 ping-pong:
    - dir=1: data<=data+1, except at MAX: data<=MAX-1, dir<=0, tc<=1.
    - dir=0: data<=data-1, except at 0: data<=1, dir<=1, tc<=1.
  - 11 up-saturate: data<=data+1 while data<MAX. At MAX, data stays MAX and tc<=1 on every further step. dir<=1.
- en=0: presc, data and dir hold; tick=tc=0. Re-enabling resumes from the held presc value, with no restart.
- Mode changes take effect on the next step. Entering ping-pong uses the current dir value.
- All arithmetic is modulo 2^W. No combinational path from inputs to outputs.
- Latency: data/tick/tc update on the same edge that samples presc == 2^N-1.

Test Plan:
(All scenarios use W=4, N=2: MAX=15, step every 4 clocks.)
1. Hold rstn=0 for 3 clocks mid-count, then release with en=1, mode=00 -> data=0, dir=1, tick=tc=0 during reset; first tick on the 4th edge after release with data=1; data=2 at edge 8.
2. load_val=14, mode=00 -> after 4 clocks data=15 (tc=0); after 8 clocks data=0 with tc=1 and tick=1 for exactly one cycle.
3. load_val=1, mode=01 -> data=0 with tc=0; next step data=15 with tc=1, dir=0.
4. load_val=14, mode=10, dir=1 -> sequence 15, 14 (tc=1, dir=0), 13, ... Then load_val=0 -> dir=1; sequence 1, 2, ... with no tc on the load cycle.
5. load_val=14, mode=11 -> data=15 (tc=0); three more steps hold data=15 with tc=1 on each step and tc=0 between steps.
6. Drop en for 10 clocks mid-prescale -> data and presc frozen, no tick. Raising en completes the step after the remaining clocks only. Assert load in the same cycle a step would occur -> data=load_val, tick=0, tc=0, presc=0.
